// File: rtl/pkt_chk.sv
// Stream checker for segmenter output: validates sop/eop framing and
// packet length, forwards legal beats one cycle later, keeps debug counters.
module pkt_chk #(
    parameter int MIN_LEN = 46,
    parameter int MAX_LEN = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    input  logic        cnt_clr,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        dout_err,
    output logic [2:0]  err_type,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        DROP
    } state_t;

    state_t      state;
    logic [10:0] len;
    logic [10:0] len_fin;
    logic        start;
    logic        fwd;
    logic        orphan;
    logic        abandon;
    logic        frame;
    logic        judge;
    logic        short_len;
    logic        long_len;
    logic        good;
    logic [1:0]  err_inc;

    function automatic logic [15:0] sat_add(
        input logic [15:0] a,
        input logic [1:0]  b
    );
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        start   = din_vld & din_sop;
        fwd     = start | (din_vld & (state == BODY));
        orphan  = din_vld & ~din_sop & (state == IDLE);
        abandon = start & (state == BODY);
        frame   = orphan | abandon;
        // length including the current beat, held at 2047
        if (start)
            len_fin = 11'd1;
        else if (len == 11'h7FF)
            len_fin = len;
        else
            len_fin = len + 11'd1;
        judge     = fwd & din_eop;
        short_len = judge & (len_fin < 11'(MIN_LEN));
        long_len  = judge & (len_fin > 11'(MAX_LEN));
        good      = judge & ~short_len & ~long_len;
        err_inc   = {1'b0, frame} + {1'b0, short_len | long_len};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_err <= 1'b0;
            err_type <= '0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            dout_vld <= fwd;
            dout_sop <= start;
            dout_eop <= judge;
            dout_err <= short_len | long_len;
            dout     <= fwd ? din : 8'h00;
            if (fwd)
                len <= len_fin;
            if (din_vld) begin
                if (din_sop) begin
                    state <= din_eop ? IDLE : BODY;
                end else begin
                    unique case (state)
                        IDLE:    state <= din_eop ? IDLE : DROP;
                        BODY:    if (din_eop) state <= IDLE;
                        DROP:    if (din_eop) state <= IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end
            // a clear on the same beat as an event discards the event
            if (cnt_clr) begin
                pkt_cnt  <= '0;
                err_cnt  <= '0;
                err_type <= '0;
            end else begin
                pkt_cnt  <= sat_add(pkt_cnt, {1'b0, good});
                err_cnt  <= sat_add(err_cnt, err_inc);
                err_type <= err_type | {frame, long_len, short_len};
            end
        end
    end

endmodule

// File: tb/tb_pkt_chk.sv
// Scoreboard bench for pkt_chk: a behavioural model predicts each
// forwarded beat and the counters; a monitor compares DUT output.
module tb_pkt_chk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic        din_vld = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_err;
    logic [2:0]  err_type;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    int total = 0;
    int bad = 0;

    logic [10:0] q[$];

    bit       m_in;
    bit       m_drop;
    int       m_len;
    int       m_pkt;
    int       m_err;
    bit [2:0] m_type;

    pkt_chk dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .cnt_clr  (cnt_clr),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop),
        .dout_err (dout_err),
        .err_type (err_type),
        .pkt_cnt  (pkt_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_vld) begin
                if (q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("beat", int'({dout, dout_sop, dout_eop, dout_err}),
                          int'(q.pop_front()));
                end
            end else begin
                check("idle_flags", int'({dout_sop, dout_eop}), 0);
            end
        end
    end

    function automatic int sat(int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_in = 0;
        m_drop = 0;
        m_len = 0;
        m_pkt = 0;
        m_err = 0;
        m_type = '0;
    endtask

    task automatic beat(bit v, bit s, bit e, logic [7:0] d, bit clr);
        bit fwd;
        bit berr;
        @(negedge clk);
        din = d;
        din_vld = v;
        din_sop = s;
        din_eop = e;
        cnt_clr = clr;
        fwd = 0;
        berr = 0;
        if (v) begin
            if (s) begin
                if (m_in) begin
                    m_err = sat(m_err + 1);
                    m_type[2] = 1;
                end
                m_in = 1;
                m_drop = 0;
                m_len = 1;
                fwd = 1;
            end else if (m_in) begin
                if (m_len < 2047) m_len++;
                fwd = 1;
            end else begin
                if (!m_drop) begin
                    m_err = sat(m_err + 1);
                    m_type[2] = 1;
                end
                m_drop = !e;
            end
            if (fwd && e) begin
                m_in = 0;
                if (m_len < 46) begin
                    berr = 1;
                    m_type[0] = 1;
                    m_err = sat(m_err + 1);
                end else if (m_len > 1500) begin
                    berr = 1;
                    m_type[1] = 1;
                    m_err = sat(m_err + 1);
                end else begin
                    m_pkt = sat(m_pkt + 1);
                end
            end
        end
        if (fwd) q.push_back({d, s, e, berr});
        if (clr) begin
            m_pkt = 0;
            m_err = 0;
            m_type = '0;
        end
    endtask

    task automatic idle(int n, bit clr);
        for (int i = 0; i < n; i++)
            beat(0, 1'($urandom), 1'($urandom), 8'($urandom), clr);
    endtask

    task automatic pkt(int n, bit s, bit e, bit clr_last, bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1, 0);
            beat(1, s && i == 0, e && i == n - 1, 8'(i),
                 clr_last && i == n - 1);
        end
        idle(3, 0);
    endtask

    task automatic check_cnt(string tag);
        check({tag, "_pkt"}, int'(pkt_cnt), m_pkt);
        check({tag, "_err"}, int'(err_cnt), m_err);
        check({tag, "_type"}, int'(err_type), int'(m_type));
    endtask

    task automatic clear();
        idle(1, 1);
        idle(2, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_out", int'({dout, dout_vld, dout_sop, dout_eop,
              dout_err, err_type}), 0);
        check("rst_cnt", int'({pkt_cnt, err_cnt}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 0);

        pkt(46, 1, 1, 0, 0);
        check_cnt("t1");
        check("t1_pkt_lit", int'(pkt_cnt), 1);

        clear();
        pkt(45, 1, 1, 0, 1);
        check("t2_short", int'(err_type), 3'b001);
        check("t2_err1", int'(err_cnt), 1);
        pkt(1500, 1, 1, 0, 1);
        check("t2_max", int'(pkt_cnt), 1);
        pkt(1501, 1, 1, 0, 0);
        check("t2_long", int'(err_type), 3'b011);
        check_cnt("t2");

        clear();
        pkt(3, 0, 1, 0, 0);
        check("t3_err", int'(err_cnt), 1);
        check("t3_frame", int'(err_type[2]), 1);
        pkt(60, 1, 1, 0, 1);
        check_cnt("t3");

        clear();
        for (int i = 0; i < 20; i++) beat(1, i == 0, 0, 8'(i), 0);
        pkt(50, 1, 1, 0, 0);
        check("t4_err", int'(err_cnt), 1);
        check("t4_pkt", int'(pkt_cnt), 1);
        check_cnt("t4");

        clear();
        pkt(1, 1, 1, 0, 0);
        check_cnt("one_byte");

        for (int i = 0; i < 10; i++) beat(1, i == 0, 0, 8'(i), 0);
        @(negedge clk);
        #1;
        din_vld = 1'b0;
        rst_n = 1'b0;
        model_reset();
        q.delete();
        #1;
        check("t5_rst", int'({dout_vld, pkt_cnt, err_cnt}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 10; i < 50; i++) beat(1, 0, i == 49, 8'(i), 0);
        idle(3, 0);
        check("t5_err", int'(err_cnt), 1);
        check_cnt("t5");

        pkt(46, 1, 1, 0, 0);
        pkt(46, 1, 1, 1, 0);
        check("t6_clr", int'({pkt_cnt, err_cnt}), 0);
        check_cnt("t6a");

        @(negedge clk);
        force dut.pkt_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_cnt;
        m_pkt = 65535;
        check("t6_force", int'(pkt_cnt), 16'hFFFF);
        pkt(50, 1, 1, 0, 1);
        check("t6_sat", int'(pkt_cnt), 16'hFFFF);
        check_cnt("t6b");

        idle(4, 0);
        check("q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
